// File: rtl/onehot_serial_encoder_pkg.sv
// Shared types and helpers for onehot_serial_encoder.
// Optional cnt output is enabled by defining ONEHOT_SERIAL_ENCODER_COUNT_EN.
package onehot_serial_encoder_pkg;

    localparam int N = 3;
    localparam int W = 2**N;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Counts set bits; callers zero-extend their vector to 64 bits.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/onehot_serial_encoder_ffs.sv
// Find-first-set: lowest set index of a 2**N-bit vector plus a found flag.
module ffs_Nbit #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] vec,
    output logic [N-1:0]    idx,
    output logic            found
);

    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest set bit is the one that sticks.
        for (int i = 2**N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = N'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_serial_encoder.sv
// Serialises a multi-hot request vector into ascending binary indices over valid/ready.
// Define ONEHOT_SERIAL_ENCODER_COUNT_EN to add the registered popcount output cnt.
module onehot_serial_encoder
    import onehot_serial_encoder_pkg::state_t;
    import onehot_serial_encoder_pkg::IDLE;
    import onehot_serial_encoder_pkg::SCAN;
    import onehot_serial_encoder_pkg::popcount;
#(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**N-1:0] req,
    input  logic            req_valid,
    output logic            req_ready,
    output logic [N-1:0]    idx,
    output logic            idx_valid,
    input  logic            idx_ready,
    output logic            idx_last,
    output logic            none
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
    ,
    output logic [N:0]      cnt
`endif
);

    localparam int W = 2**N;

    state_t         state, state_d;
    logic [W-1:0]   pend, pend_d;
    logic           none_d;
    logic           found;

    ffs_Nbit #(.N(N)) u_ffs (
        .vec   (pend),
        .idx   (idx),
        .found (found)
    );

    // pend is zero outside SCAN, so idx and idx_last fall to 0 there.
    assign idx_last = (popcount(64'(pend)) == 1);

    always_comb begin
        state_d   = state;
        pend_d    = pend;
        none_d    = 1'b0;
        req_ready = 1'b0;
        idx_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req != '0) begin
                        pend_d  = req;
                        state_d = SCAN;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                idx_valid = found;
                if (idx_ready) begin
                    pend_d = pend & ~(W'(1) << idx);
                    if (idx_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            none  <= 1'b0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
            none  <= none_d;
        end
    end

`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (req_valid && req_ready) begin
            cnt <= (N+1)'(popcount(64'(req)));
        end
    end
`endif

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Scoreboard bench for onehot_serial_encoder with N=3 and directed stimulus.
module tb_onehot_serial_encoder;

    localparam int N = 3;
    localparam int W = 2**N;

    typedef struct {
        logic [N-1:0] idx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] idx;
    logic         idx_valid;
    logic         idx_ready;
    logic         idx_last;
    logic         none;
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
    logic [N:0]   cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    onehot_serial_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .idx       (idx),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_last  (idx_last),
        .none      (none)
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected emission order: ascending indices, last flag on the highest set bit.
    task automatic push_vec(input logic [W-1:0] vec);
        int hi;
        exp_t e;
        hi = -1;
        for (int i = 0; i < W; i++) if (vec[i]) hi = i;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                e.idx  = N'(i);
                e.last = (i == hi);
                q.push_back(e);
            end
        end
    endtask

    // Drives vec until accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] vec);
        bit ok;
        ok = 1'b0;
        push_vec(vec);
        req       = vec;
        req_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req       = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (req_ready && q.size() == 0) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && idx_valid && idx_ready) begin
            if (q.size() == 0) begin
                check("unexpected_idx", 32'(idx), 32'hFFFF_FFFF);
            end else begin
                check("idx", 32'(idx), 32'(q[0].idx));
                check("idx_last", 32'(idx_last), 32'(q[0].last));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_valid = 1'b0;
        idx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_idx_last", 32'(idx_last), 32'd0);
        check("rst_none", 32'(none), 32'd0);
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
        check("rst_cnt", 32'(cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the middle of a stalled scan.
        send(8'b1010_0000);
        @(negedge clk);
        check("midscan_valid", 32'(idx_valid), 32'd1);
        check("midscan_idx", 32'(idx), 32'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_scan_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_scan_req_ready", 32'(req_ready), 32'd1);
        check("rst_scan_idx", 32'(idx), 32'd0);
        check("rst_scan_idx_last", 32'(idx_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        idx_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_no_idx", 32'(idx_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Single-bit vector.
        send(8'b0000_0100);
        @(negedge clk);
        check("single_valid", 32'(idx_valid), 32'd1);
        check("single_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("single_back_idle", 32'(req_ready), 32'd1);
        check("single_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Three bits on consecutive cycles.
        send(8'b1001_0010);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("triple_valid", 32'(idx_valid), 32'd1);
        end
        @(negedge clk);
        check("triple_back_idle", 32'(req_ready), 32'd1);
        check("triple_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        // All ones with stalls: idx must hold the next expected entry.
        send(8'hFF);
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            idx_ready = ((c % 3) == 0);
            @(negedge clk);
            if (!idx_ready && q.size() > 0) begin
                check("stall_valid", 32'(idx_valid), 32'd1);
                check("stall_idx", 32'(idx), 32'(q[0].idx));
                check("stall_last", 32'(idx_last), 32'(q[0].last));
            end
            @(posedge clk);
            #1;
        end
        check("ff_drained", 32'(q.size()), 32'd0);
        idx_ready = 1'b1;
        wait_idle();

        // Zero vector.
        send(8'h00);
        @(negedge clk);
        check("zero_none_pulse", 32'(none), 32'd1);
        check("zero_no_idx", 32'(idx_valid), 32'd0);
        check("zero_req_ready", 32'(req_ready), 32'd1);
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
        check("zero_cnt", 32'(cnt), 32'd0);
`endif
        @(negedge clk);
        check("zero_none_drop", 32'(none), 32'd0);
        check("zero_no_idx2", 32'(idx_valid), 32'd0);
        @(posedge clk);
        #1;

        // New request held during scan is taken only after returning to IDLE.
        send(8'h81);
        req       = 8'h7E;
        req_valid = 1'b1;
        @(negedge clk);
        check("busy_req_ready", 32'(req_ready), 32'd0);
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
        check("cnt_81", 32'(cnt), 32'd2);
`endif
        send(8'h7E);
`ifdef ONEHOT_SERIAL_ENCODER_COUNT_EN
        @(negedge clk);
        check("cnt_7e", 32'(cnt), 32'd6);
        @(posedge clk);
        #1;
`endif
        wait_idle();
        check("final_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
